// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: ALU control codes and multiply FSM state
// shared by the EX-stage multiply sequencer and its datapath.
package mul_sequencer_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_SRAI = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: EX-stage <-> multiply sequencer bundle.
// master = EX stage (drives op/operands), slave = sequencer (drives stall/result).
interface mul_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic [CTRL_W-1:0] ALUCtrl_i;
    logic              valid_i;
    logic              flush_i;
    logic [WIDTH-1:0]  data1_i;
    logic [WIDTH-1:0]  data2_i;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [WIDTH-1:0]  result_o;

    modport master (
        output ALUCtrl_i, valid_i, flush_i, data1_i, data2_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  ALUCtrl_i, valid_i, flush_i, data1_i, data2_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp: shift-add multiply datapath (mcand/mplr/acc/cnt).
// Ports: clk_i, rst_i, load_i (latch operands), step_i (one iteration),
//        mcand_i/mplr_i operands, last_o (final step now), acc_o product.
module mul_shift_add_dp
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplr_i,
    output logic             last_o,
    output logic [WIDTH-1:0] acc_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            mcand_d = mcand_i;
            mplr_d  = mplr_i;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (step_i) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Stop early once no multiplier bits remain after this step.
    assign last_o = ((mplr_q >> 1) == '0) ||
                    (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: EX-stage multi-cycle MUL controller (IDLE/RUN/DONE).
// Ports: clk_i, rst_i (async, active-high), bus (slave): op/operands in,
//        stall_o/busy_o/done_o/result_o out.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter int                CTRL_W   = 4,
    parameter logic [CTRL_W-1:0] MUL_CODE = CTRL_W'(ALU_MUL)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mul_sequencer_if.slave bus
);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] acc;

    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Reset gates accept so stall drops the moment rst_i rises.
    assign accept = !rst_i && bus.valid_i && !bus.flush_i &&
                    (bus.ALUCtrl_i == MUL_CODE);

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .step_i  (step),
        .mcand_i (bus.data1_i),
        .mplr_i  (bus.data2_i),
        .last_o  (last),
        .acc_o   (acc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (accept) state_d = ST_RUN;
                ST_RUN:  if (last) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall  = 1'b0;
        done   = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        result = result_q;
        busy   = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                load  = accept;
                stall = accept;
            end
            ST_RUN: begin
                step  = !bus.flush_i;
                stall = !bus.flush_i;
            end
            ST_DONE: begin
                // A flushed DONE leaves the last completed product visible.
                if (!bus.flush_i) begin
                    done   = 1'b1;
                    result = acc;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        result_d = result;
    end

    assign bus.stall_o  = stall;
    assign bus.busy_o   = busy;
    assign bus.done_o   = done;
    assign bus.result_o = result;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer.
// Drives at posedge+1, samples at negedge.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mul_sequencer_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    mul_sequencer u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.valid_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.ALUCtrl_i = ALU_ADD;
        bus.data1_i   = '0;
        bus.data2_i   = '0;
    endtask

    // Starts at posedge+1; returns at posedge+1 of the cycle after DONE+1.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int k, input logic [31:0] exp,
                           input string tag);
        int          stalls;
        int          dcyc;
        logic [31:0] res;
        stalls = 0;
        dcyc   = -1;
        res    = '0;
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_MUL;
        bus.data1_i   = a;
        bus.data2_i   = b;
        for (int c = 0; c < 40 && dcyc < 0; c++) begin
            @(negedge clk);
            if (bus.stall_o) stalls++;
            if (bus.done_o) begin
                dcyc = c;
                res  = bus.result_o;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                // Garbage after accept must be ignored.
                bus.valid_i   = 1'b0;
                bus.ALUCtrl_i = ALU_ADD;
                bus.data1_i   = '1;
                bus.data2_i   = '1;
            end
        end
        chk({tag, " done_cycle"}, 32'(dcyc), 32'(k + 1));
        chk({tag, " stalls"}, 32'(stalls), 32'(k + 1));
        chk({tag, " result"}, res, exp);
        @(negedge clk);
        chk({tag, " post_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, " post_done"}, 32'(bus.done_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pass_through(input logic vld, input logic [3:0] op,
                                input string tag);
        logic any;
        any = 1'b0;
        bus.valid_i   = vld;
        bus.ALUCtrl_i = op;
        bus.data1_i   = 32'd7;
        bus.data2_i   = 32'd6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            any = any | bus.stall_o | bus.busy_o | bus.done_o;
            @(posedge clk);
            #1;
        end
        chk({tag, " no_activity"}, 32'(any), 32'd0);
        idle_inputs();
    endtask

    initial begin
        int          d1;
        int          d2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st_done;
        logic        st_acc;

        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();

        @(negedge clk);
        chk("rst stall", 32'(bus.stall_o), 32'd0);
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst done", 32'(bus.done_o), 32'd0);
        chk("rst result", bus.result_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h1, "ones");
        run_mul(32'h1234_5678, 32'h0, 1, 32'h0, "zero");
        run_mul(32'd7, 32'd6, 3, 32'd42, "7x6");

        pass_through(1'b1, ALU_ADD, "add");
        pass_through(1'b0, ALU_MUL, "mul_novalid");

        // Flush on the 2nd RUN cycle of 5*3.
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_MUL;
        bus.data1_i   = 32'd5;
        bus.data2_i   = 32'd3;
        @(negedge clk);
        chk("fl accept_stall", 32'(bus.stall_o), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("fl run1_busy", 32'(bus.busy_o), 32'd1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("fl stall", 32'(bus.stall_o), 32'd0);
        chk("fl done", 32'(bus.done_o), 32'd0);
        chk("fl result", bus.result_o, 32'd42);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        st_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            st_done = st_done | bus.done_o | bus.busy_o;
            @(posedge clk);
            #1;
        end
        chk("fl idle_after", 32'(st_done), 32'd0);
        chk("fl result_kept", bus.result_o, 32'd42);

        // Back-to-back: 3*4 then 2*2, valid held through DONE.
        d1 = -1;
        d2 = -1;
        r1 = '0;
        r2 = '0;
        st_done = 1'b1;
        st_acc  = 1'b0;
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_MUL;
        bus.data1_i   = 32'd3;
        bus.data2_i   = 32'd4;
        for (int c = 0; c < 40 && d2 < 0; c++) begin
            @(negedge clk);
            if (d1 >= 0 && c == d1 + 1) st_acc = bus.stall_o;
            if (bus.done_o) begin
                if (d1 < 0) begin
                    d1 = c;
                    r1 = bus.result_o;
                    st_done = bus.stall_o;
                end else begin
                    d2 = c;
                    r2 = bus.result_o;
                end
            end
            @(posedge clk);
            #1;
            if (c == d1) begin
                bus.data1_i = 32'd2;
                bus.data2_i = 32'd2;
            end
            if (d1 >= 0 && c == d1 + 1) bus.valid_i = 1'b0;
        end
        chk("b2b done1_cycle", 32'(d1), 32'd4);
        chk("b2b result1", r1, 32'd12);
        chk("b2b done_stall", 32'(st_done), 32'd0);
        chk("b2b accept_stall", 32'(st_acc), 32'd1);
        chk("b2b gap", 32'(d2 - d1), 32'd4);
        chk("b2b result2", r2, 32'd4);
        idle_inputs();
        @(posedge clk);
        #1;

        // Async reset in the middle of a long RUN.
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = ALU_MUL;
        bus.data1_i   = 32'h0001_0000;
        bus.data2_i   = 32'h8000_0000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("mr busy_before", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr stall", 32'(bus.stall_o), 32'd0);
        chk("mr busy", 32'(bus.busy_o), 32'd0);
        chk("mr done", 32'(bus.done_o), 32'd0);
        chk("mr result", bus.result_o, 32'd0);
        idle_inputs();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_mul(32'd9, 32'd9, 4, 32'd81, "9x9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle multiply controller for the EX stage of the pipelined RISC-V core. When the ALU control code in EX selects MUL, it latches the operands and freezes the pipeline. It then runs an iterative shift-add multiply, presents the low 32 bits of the product in the release cycle, and returns to idle. All other ALU operations pass through with no stall; the single-cycle ALU handles them.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control code width
- MUL_CODE, 4'b0101, ALU control code meaning MUL

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ALUCtrl_i  in  CTRL_W  ALU control code of the instruction in EX
- valid_i  in  1  EX holds a real instruction (not a bubble)
- flush_i  in  1  cancel the EX instruction (branch/exception flush)
- data1_i  in  WIDTH  rs1 operand (multiplicand)
- data2_i  in  WIDTH  rs2 operand (multiplier)
- stall_o  out  1  hold PC, IF/ID, ID/EX; EX not written to EX/MEM
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse: result_o valid for the EX instruction
- result_o  out  WIDTH  low WIDTH bits of data1*data2

## Operation
- States: IDLE, RUN, DONE. Internal registers: mcand, mplr, acc (all WIDTH bits), cnt (log2(WIDTH)+1 bits).
- IDLE:
  - accept = valid_i && ALUCtrl_i==MUL_CODE && !flush_i.
  - On accept: mcand<=data1_i, mplr<=data2_i, acc<=0, cnt<=0, go to RUN; stall_o=1 combinationally in the same cycle.
  - Otherwise stall_o=0 and the state holds.
- RUN, one step per cycle:
  - If mplr[0]: acc<=acc+mcand (mod 2^WIDTH).
  - mcand<=mcand<<1 (truncated); mplr<=mplr>>1 (logical); cnt<=cnt+1.
  - Go to DONE when (mplr>>1)==0 or cnt==WIDTH-1; otherwise stay.
  - stall_o=1.
- DONE: done_o=1, result_o=acc, stall_o=0, so the pipeline advances and EX/MEM captures result_o. Next state is IDLE.
- Operands are latched at accept. Changes on data*_i, ALUCtrl_i or valid_i during RUN/DONE are ignored.
- Signed vs unsigned is irrelevant: only the low half of the product is produced.
- flush_i is honoured in every state and has priority:
  - Next state IDLE; done_o=0; stall_o=0 in that cycle.
  - result_o keeps its previous value.
- result_o holds the last completed product until the next DONE.
- Reset (asynchronous, any state, including mid-RUN): state IDLE; acc, mcand, mplr, cnt, result_o = 0; stall_o=0, busy_o=0, done_o=0.

## Timing
- Let k = position of the highest set bit of data2 + 1, with k=1 when data2=0; range 1..WIDTH.
- A MUL occupies EX for k+2 cycles: accept (stall), k RUN cycles (stall), DONE (no stall). That is k+1 stall cycles.
- done_o asserts exactly k+1 cycles after the accept cycle, for 1 cycle.
- Back-to-back MULs: the DONE cycle does not accept; the next MUL is accepted in the following IDLE cycle (zero dead cycles beyond that).
- busy_o=1 in RUN and DONE only.
- Outputs stall_o and busy_o are combinational from state plus inputs. done_o and result_o are combinational from registered state/acc.

## Structure
- Shared package holds:
  - ALU control code constants (AND, XOR, SLL, ADD, SUB, MUL, SRAI), so MUL_CODE defaults from the package.
  - The state enum {IDLE, RUN, DONE}.
- One sub-module, mul_shift_add_dp: the mcand/mplr/acc/cnt registers and the step adder, with load/step inputs and last/acc outputs.
- mul_sequencer keeps the FSM and the stall/flush logic.

## Test plan
- ALUCtrl=MUL, data1=7, data2=6 -> accept, k=3, stall_o high 4 cycles, done_o on cycle 5 with result_o=42.
- data1=0xFFFFFFFF, data2=0xFFFFFFFF -> k=32, 33 stall cycles, result_o=0x00000001.
- data1=0x12345678, data2=0 -> k=1, 2 stall cycles, result_o=0.
- ALUCtrl=ADD (4'b0011), valid_i=1; and ALUCtrl=MUL with valid_i=0 -> stall_o stays 0, busy_o 0, no done_o.
- MUL 5*3 (expected result_o=15), flush_i asserted on the 2nd RUN cycle -> stall_o=0 that cycle, IDLE next, no done_o, result_o keeps its old value. Then two back-to-back MULs (3*4, 2*2) -> done_o pulses with 12 then 4, separated by exactly one accept cycle.
- rst_i pulsed mid-RUN (asynchronously, between clock edges) -> outputs immediately 0, IDLE; a subsequent MUL 9*9 completes with result_o=81.
